// File: rtl/io_vip_sequencer_if.sv
// Control, table-write and pattern-output bundle for io_vip_sequencer.
// master drives writes and playback control; slave (the sequencer) drives the pattern and status.
interface io_vip_sequencer_if #(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_value;
    logic [CNT_WIDTH-1:0] wr_hold;
    logic [AW:0]          num_entries;
    logic                 loop_en;
    logic                 start;
    logic                 stop;
    logic [WIDTH-1:0]     out;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        entry_idx;

    modport master (
        output wr_en, wr_addr, wr_value, wr_hold, num_entries, loop_en, start, stop,
        input  out, busy, done, entry_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_value, wr_hold, num_entries, loop_en, start, stop,
        output out, busy, done, entry_idx
    );
endinterface

// File: rtl/io_vip_sequencer.sv
// Plays a (value, hold) table onto a registered IO bus, one-shot or looped, with abort and done pulse.
// Entry 0 appears one cycle after start; no backpressure, each entry is driven for max(hold,1) cycles.
module io_vip_sequencer #(
    parameter int               WIDTH         = 1,
    parameter int               DEPTH         = 16,
    parameter int               CNT_WIDTH     = 16,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    io_vip_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0]     value;
        logic [CNT_WIDTH-1:0] hold;
    } entry_t;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t               state;
    entry_t               tbl [DEPTH];
    logic [WIDTH-1:0]     out_q;
    logic                 busy_q;
    logic                 done_q;
    logic [AW-1:0]        idx_q;
    logic [AW-1:0]        last_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    entry_t               first_entry;
    entry_t               next_entry;
    logic [AW-1:0]        next_idx;
    logic [AW:0]          n_eff;
    logic [AW-1:0]        last_idx;
    logic                 wr_ok;

    function automatic logic [CNT_WIDTH-1:0] hold_load(input logic [CNT_WIDTH-1:0] h);
        return (h == '0) ? CNT_WIDTH'(1) : h;
    endfunction

    assign wr_ok = bus.wr_en && (state == IDLE);

    // A same-cycle write to entry 0 must be visible to a start on that edge.
    always_comb begin
        first_entry = tbl[0];
        if (wr_ok && (bus.wr_addr == '0)) begin
            first_entry.value = bus.wr_value;
            first_entry.hold  = bus.wr_hold;
        end
    end

    assign next_idx   = idx_q + AW'(1);
    assign next_entry = tbl[next_idx];
    assign n_eff      = (bus.num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_entries;
    assign last_idx   = AW'(n_eff - (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tbl[bus.wr_addr] <= '{value: bus.wr_value, hold: bus.wr_hold};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            out_q  <= DEFAULT_VALUE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            last_q <= '0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && (bus.num_entries != '0)) begin
                        state  <= PLAY;
                        busy_q <= 1'b1;
                        out_q  <= first_entry.value;
                        idx_q  <= '0;
                        last_q <= last_idx;
                        cnt_q  <= hold_load(first_entry.hold);
                    end
                end
                PLAY: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        out_q  <= DEFAULT_VALUE;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_WIDTH'(1)) begin
                        if (idx_q != last_q) begin
                            out_q <= next_entry.value;
                            idx_q <= next_idx;
                            cnt_q <= hold_load(next_entry.hold);
                        end else if (bus.loop_en) begin
                            out_q <= tbl[0].value;
                            idx_q <= '0;
                            cnt_q <= hold_load(tbl[0].hold);
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            out_q  <= DEFAULT_VALUE;
                            idx_q  <= '0;
                            cnt_q  <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.entry_idx = idx_q;
endmodule

// File: tb/tb_io_vip_sequencer.sv
// Directed bench for io_vip_sequencer with WIDTH=4, DEPTH=16: playback, loop, abort, clamp, write gating, reset.
module tb_io_vip_sequencer;
    localparam int WIDTH     = 4;
    localparam int DEPTH     = 16;
    localparam int CNT_WIDTH = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [19:0] abc_val;
    logic [19:0] abc_idx;

    io_vip_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    io_vip_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH), .DEFAULT_VALUE(4'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [3:0] val, input int hold);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'(addr);
        bus.wr_value = val;
        bus.wr_hold  = 16'(hold);
        tick();
        bus.wr_en    = 1'b0;
    endtask

    task automatic do_start(input int n);
        bus.num_entries = 5'(n);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        chk({tag, "_out"},  32'(bus.out),       32'h0);
        chk({tag, "_busy"}, 32'(bus.busy),      32'h0);
        chk({tag, "_done"}, 32'(bus.done),      32'(exp_done));
        chk({tag, "_idx"},  32'(bus.entry_idx), 32'h0);
    endtask

    // Expects A,A,A,B,C from the cycle after start; leaves time on the cycle after C.
    task automatic expect_abc(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_out"},  32'(bus.out),       32'(abc_val[19-4*i -: 4]));
            chk({tag, "_idx"},  32'(bus.entry_idx), 32'(abc_idx[19-4*i -: 4]));
            chk({tag, "_busy"}, 32'(bus.busy),      32'h1);
            chk({tag, "_done"}, 32'(bus.done),      32'h0);
            tick();
        end
    endtask

    task automatic load_abc();
        write_entry(0, 4'hA, 3);
        write_entry(1, 4'hB, 1);
        write_entry(2, 4'hC, 0);
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        abc_val         = 20'hAAABC;
        abc_idx         = 20'h00012;
        reset           = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_value    = '0;
        bus.wr_hold     = '0;
        bus.num_entries = '0;
        bus.loop_en     = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset", 1'b0);

        // One-shot playback.
        load_abc();
        do_start(3);
        expect_abc("oneshot");
        check_idle("oneshot_end", 1'b1);
        tick();
        chk("oneshot_done_1cyc", 32'(bus.done), 32'h0);

        // Looped playback, loop dropped during second pass.
        bus.loop_en = 1'b1;
        do_start(3);
        expect_abc("loop_p1");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) bus.loop_en = 1'b0;
            chk("loop_p2_out",  32'(bus.out),  32'(abc_val[19-4*i -: 4]));
            chk("loop_p2_done", 32'(bus.done), 32'h0);
            tick();
        end
        check_idle("loop_end", 1'b1);

        // Abort while entry 1 is driven.
        do_start(3);
        tick();
        tick();
        tick();
        chk("stop_pre_out", 32'(bus.out),       32'hB);
        chk("stop_pre_idx", 32'(bus.entry_idx), 32'h1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("stop", 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("stop_no_done", 32'(bus.done), 32'h0);
            tick();
        end
        do_start(3);
        expect_abc("replay");
        check_idle("replay_end", 1'b1);

        // Zero-length start is ignored.
        do_start(0);
        for (int i = 0; i < 3; i++) begin
            check_idle("zero_n", 1'b0);
            tick();
        end

        // num_entries above DEPTH clamps to all 16 entries.
        for (int e = 0; e < DEPTH; e++) write_entry(e, 4'(e), e % 3);
        do_start(20);
        for (int e = 0; e < DEPTH; e++) begin
            int h;
            h = (e % 3 == 0) ? 1 : e % 3;
            for (int k = 0; k < h; k++) begin
                chk("clamp_out",  32'(bus.out),       32'(e));
                chk("clamp_idx",  32'(bus.entry_idx), 32'(e));
                chk("clamp_busy", 32'(bus.busy),      32'h1);
                tick();
            end
        end
        check_idle("clamp_end", 1'b1);

        // Writes during playback are dropped.
        load_abc();
        do_start(3);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'h0;
        bus.wr_value = 4'h5;
        bus.wr_hold  = 16'd3;
        tick();
        bus.wr_en    = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check_idle("busywr_end", 1'b1);
        do_start(3);
        expect_abc("busywr_replay");
        check_idle("busywr_replay_end", 1'b1);

        // Write and start on the same edge: new entry 0 is played.
        bus.wr_en       = 1'b1;
        bus.wr_addr     = 4'h0;
        bus.wr_value    = 4'h7;
        bus.wr_hold     = 16'd2;
        bus.num_entries = 5'd1;
        bus.start       = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk("wrstart_out0", 32'(bus.out),  32'h7);
        chk("wrstart_busy", 32'(bus.busy), 32'h1);
        tick();
        chk("wrstart_out1", 32'(bus.out),  32'h7);
        tick();
        check_idle("wrstart_end", 1'b1);

        // Reset in the middle of a long hold.
        write_entry(0, 4'h9, 100);
        do_start(1);
        for (int i = 0; i < 10; i++) tick();
        chk("rst_mid_out",  32'(bus.out),  32'h9);
        chk("rst_mid_busy", 32'(bus.busy), 32'h1);
        reset           = 1'b1;
        bus.start       = 1'b1;
        bus.num_entries = 5'd1;
        tick();
        check_idle("rst_hit", 1'b0);
        tick();
        check_idle("rst_hold", 1'b0);
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("rst_after", 1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
